// File: rtl/italos_video_pkg.sv
// Shared video definitions: fade level width/full scale, fade FSM encoding,
// and the pixel word width macro (3 channels of CW bits, packed {R,G,B}).
`ifndef ITALOS_PIXEL_W
`define ITALOS_PIXEL_W(cw) (3*(cw))
`endif

package italos_video_pkg;
  localparam int FADE_LVL_W = 5;
  localparam logic [FADE_LVL_W-1:0] FADE_FULL = 5'd16;

  typedef enum logic {
    FADE_IDLE = 1'b0,
    FADE_RUN  = 1'b1
  } fade_state_e;
endpackage

// File: rtl/pixel_colouriser_if.sv
// Pixel stream bundle between the renderers, the colouriser and the DAC pins.
// Stream protocol: no valid/ready pair; every clock carries one pixel and the sink never stalls.
interface pixel_colouriser_if #(
  parameter int CW     = 3,
  parameter int LAYERS = 4
);
  logic                                   video_on;
  logic                                   hsync_in;
  logic                                   vsync_in;
  logic [LAYERS-1:0]                      layer_mask;
  logic [LAYERS*`ITALOS_PIXEL_W(CW)-1:0]  layer_rgb;
  logic [`ITALOS_PIXEL_W(CW)-1:0]         rgb_out;
  logic                                   hsync_out;
  logic                                   vsync_out;

  modport master (
    output video_on, hsync_in, vsync_in, layer_mask, layer_rgb,
    input  rgb_out, hsync_out, vsync_out
  );

  modport slave (
    input  video_on, hsync_in, vsync_in, layer_mask, layer_rgb,
    output rgb_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/fade_scaler.sv
// Combinational per-channel brightness scaling: out = (c * level) >> 4.
// Level 16 is unity, level 0 is black; the result always fits in CW bits.
module fade_scaler
  import italos_video_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic [`ITALOS_PIXEL_W(CW)-1:0] pix,
  input  logic [FADE_LVL_W-1:0]          level,
  output logic [`ITALOS_PIXEL_W(CW)-1:0] scaled
);
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [CW+FADE_LVL_W-1:0] prod;
    logic [3:0]               unused_frac;
    logic                     unused_ovf;

    assign prod = {{FADE_LVL_W{1'b0}}, pix[ch*CW +: CW]} * {{CW{1'b0}}, level};
    // Top bit is only set for level > 16, which never occurs.
    assign {unused_ovf, scaled[ch*CW +: CW], unused_frac} = prod;
  end
endmodule

// File: rtl/pixel_colouriser.sv
// Layer priority merge, blanking and optional frame-synchronous fade; 2-clock pipeline.
// Fade logic is present only when PIXEL_COLOURISER_FADE_EN is defined.
module pixel_colouriser
  import italos_video_pkg::*;
#(
  parameter int CW          = 3,
  parameter int LAYERS      = 4,
  parameter int FADE_FRAMES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pixel_colouriser_if.slave              pix,
  input  logic                           frame_start,
  input  logic                           bg_wr,
  input  logic [`ITALOS_PIXEL_W(CW)-1:0] bg_rgb,
  input  logic                           fade_req,
  input  logic                           fade_dir,
  output logic                           fade_busy,
  output logic [FADE_LVL_W-1:0]          fade_level,
  output fade_state_e                    fade_state
);
  localparam int PW = `ITALOS_PIXEL_W(CW);

  logic [PW-1:0] bg_q;
  logic [PW-1:0] sel_pix;
  logic [PW-1:0] s1_pix;
  logic          s1_hs;
  logic          s1_vs;
  logic [PW-1:0] s2_d;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    sel_pix = bg_q;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (pix.layer_mask[k]) sel_pix = pix.layer_rgb[k*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_q          <= '0;
      s1_pix        <= '0;
      s1_hs         <= 1'b1;
      s1_vs         <= 1'b1;
      pix.rgb_out   <= '0;
      pix.hsync_out <= 1'b1;
      pix.vsync_out <= 1'b1;
    end else begin
      if (bg_wr) bg_q <= bg_rgb;
      s1_pix        <= pix.video_on ? sel_pix : '0;
      s1_hs         <= pix.hsync_in;
      s1_vs         <= pix.vsync_in;
      pix.rgb_out   <= s2_d;
      pix.hsync_out <= s1_hs;
      pix.vsync_out <= s1_vs;
    end
  end

`ifdef PIXEL_COLOURISER_FADE_EN
  localparam int CNT_W = $clog2(FADE_FRAMES + 1);

  fade_state_e             state_q, state_d;
  logic                    dir_q, dir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FADE_LVL_W-1:0]   lvl_q, lvl_d;
  logic [FADE_LVL_W-1:0]   req_target;
  logic [FADE_LVL_W-1:0]   run_target;

  assign req_target = fade_dir ? FADE_FULL : '0;
  assign run_target = dir_q    ? FADE_FULL : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FADE_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= FADE_FULL;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  // A frame_start arriving with the accepted request is not counted.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    case (state_q)
      FADE_IDLE: begin
        if (fade_req && (lvl_q != req_target)) begin
          dir_d   = fade_dir;
          cnt_d   = '0;
          state_d = FADE_RUN;
        end
      end
      FADE_RUN: begin
        if (frame_start) begin
          if (cnt_q == CNT_W'(FADE_FRAMES - 1)) begin
            cnt_d = '0;
            lvl_d = dir_q ? lvl_q + 5'd1 : lvl_q - 5'd1;
            if (lvl_d == run_target) state_d = FADE_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FADE_IDLE;
    endcase
  end

  fade_scaler #(.CW(CW)) u_fade_scaler (
    .pix    (s1_pix),
    .level  (lvl_q),
    .scaled (s2_d)
  );

  assign fade_level = lvl_q;
  assign fade_busy  = (state_q == FADE_RUN);
  assign fade_state = state_q;
`else
  localparam int unused_fade_frames = FADE_FRAMES;
  logic unused_fade_in;

  assign unused_fade_in = ^{frame_start, fade_req, fade_dir};
  assign s2_d       = s1_pix;
  assign fade_level = FADE_FULL;
  assign fade_busy  = 1'b0;
  assign fade_state = FADE_IDLE;
`endif
endmodule

// File: tb/tb_pixel_colouriser.sv
// Directed bench for pixel_colouriser: a cycle model derived from the pixel rules
// is compared every cycle, plus hand-computed literal expectations.
module tb_pixel_colouriser;
  import italos_video_pkg::*;

  localparam int CW     = 3;
  localparam int LAYERS = 4;
  localparam int FF     = 2;
  localparam int PW     = 3 * CW;
`ifdef PIXEL_COLOURISER_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          bg_wr;
  logic [PW-1:0] bg_rgb;
  logic          fade_req;
  logic          fade_dir;
  logic          fade_busy;
  logic [4:0]    fade_level;
  fade_state_e   fade_state;

  pixel_colouriser_if #(.CW(CW), .LAYERS(LAYERS)) pif ();

  pixel_colouriser #(.CW(CW), .LAYERS(LAYERS), .FADE_FRAMES(FF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix         (pif.slave),
    .frame_start (frame_start),
    .bg_wr       (bg_wr),
    .bg_rgb      (bg_rgb),
    .fade_req    (fade_req),
    .fade_dir    (fade_dir),
    .fade_busy   (fade_busy),
    .fade_level  (fade_level),
    .fade_state  (fade_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [PW-1:0] pix;
    logic          hs;
    logic          vs;
  } stage_t;

  stage_t        pipe_q[$];
  logic [PW-1:0] m_bg;
  logic [PW-1:0] m_rgb;
  logic          m_hs;
  logic          m_vs;
  int            m_lvl;
  bit            m_busy;
  bit            m_dir;
  int            m_start;
  int            m_frames;

  function automatic logic [PW-1:0] pick(input logic [LAYERS-1:0] mask,
                                         input logic [LAYERS*PW-1:0] rgb,
                                         input logic [PW-1:0] bg);
    for (int k = 0; k < LAYERS; k++)
      if (mask[k]) return rgb[k*PW +: PW];
    return bg;
  endfunction

  function automatic logic [PW-1:0] scale(input logic [PW-1:0] p, input int lvl);
    logic [PW-1:0] r;
    for (int ch = 0; ch < 3; ch++) begin
      int c;
      c = int'(p[ch*CW +: CW]);
      r[ch*CW +: CW] = CW'((c * lvl) / 16);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q   = {};
      pipe_q.push_back('{pix: '0, hs: 1'b1, vs: 1'b1});
      m_bg     = '0;
      m_rgb    = '0;
      m_hs     = 1'b1;
      m_vs     = 1'b1;
      m_lvl    = 16;
      m_busy   = 1'b0;
      m_dir    = 1'b0;
      m_start  = 16;
      m_frames = 0;
    end else begin
      stage_t old_s;
      stage_t new_s;
      old_s = pipe_q.pop_front();
      m_rgb = scale(old_s.pix, m_lvl);
      m_hs  = old_s.hs;
      m_vs  = old_s.vs;
      new_s.pix = pif.video_on ? pick(pif.layer_mask, pif.layer_rgb, m_bg) : '0;
      new_s.hs  = pif.hsync_in;
      new_s.vs  = pif.vsync_in;
      pipe_q.push_back(new_s);
      if (bg_wr) m_bg = bg_rgb;
      if (FADE_EN) begin
        if (!m_busy) begin
          if (fade_req && (m_lvl != (fade_dir ? 16 : 0))) begin
            m_busy   = 1'b1;
            m_dir    = fade_dir;
            m_start  = m_lvl;
            m_frames = 0;
          end
        end else if (frame_start) begin
          m_frames++;
          m_lvl = m_dir ? m_start + m_frames / FF : m_start - m_frames / FF;
          if (m_lvl == (m_dir ? 16 : 0)) m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("rgb_out",    32'(pif.rgb_out),   32'(m_rgb));
    check("hsync_out",  32'(pif.hsync_out), 32'(m_hs));
    check("vsync_out",  32'(pif.vsync_out), 32'(m_vs));
    check("fade_level", 32'(fade_level),    32'(m_lvl));
    check("fade_busy",  32'(fade_busy),     32'(m_busy));
    check("fade_state", 32'(fade_state),    32'(m_busy ? FADE_RUN : FADE_IDLE));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input logic dir);
    fade_req = 1'b1;
    fade_dir = dir;
    tick(1);
    fade_req = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick($urandom_range(1, 3));
    end
  endtask

  task automatic set_layers(input logic [LAYERS-1:0] mask,
                            input logic [PW-1:0] l0, input logic [PW-1:0] l1,
                            input logic [PW-1:0] l2, input logic [PW-1:0] l3);
    pif.layer_mask = mask;
    pif.layer_rgb  = {l3, l2, l1, l0};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    bg_wr        = 1'b0;
    bg_rgb       = '0;
    fade_req     = 1'b0;
    fade_dir     = 1'b0;
    pif.video_on = 1'b0;
    pif.hsync_in = 1'b1;
    pif.vsync_in = 1'b1;
    set_layers(4'b0000, '0, '0, '0, '0);

    #12;
    check("reset_rgb",   32'(pif.rgb_out),   32'h0);
    check("reset_hsync", 32'(pif.hsync_out), 32'h1);
    check("reset_vsync", 32'(pif.vsync_out), 32'h1);
    check("reset_level", 32'(fade_level),    32'd16);
    check("reset_busy",  32'(fade_busy),     32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Background 007 with no layers set.
    pif.video_on = 1'b1;
    bg_wr  = 1'b1;
    bg_rgb = 9'o007;
    tick(1);
    bg_wr = 1'b0;
    tick(2);
    check("bg_007", 32'(pif.rgb_out), 32'(9'o007));

    // Priority: layers 1 and 2 set, layer 1 wins.
    set_layers(4'b0110, 9'o777, 9'o700, 9'o070, 9'o333);
    tick(2);
    check("priority_l1", 32'(pif.rgb_out), 32'(9'o700));
    set_layers(4'b1000, 9'o777, 9'o700, 9'o070, 9'o333);
    tick(2);
    check("priority_l3", 32'(pif.rgb_out), 32'(9'o333));

    // Blanking overrides any layer.
    set_layers(4'b0001, 9'o777, 9'o700, 9'o070, 9'o333);
    pif.video_on = 1'b0;
    tick(2);
    check("blank", 32'(pif.rgb_out), 32'h0);
    pif.video_on = 1'b1;

    // One-cycle hsync low pulse shows up exactly two clocks later.
    pif.hsync_in = 1'b0;
    tick(1);
    pif.hsync_in = 1'b1;
    check("hsync_d1", 32'(pif.hsync_out), 32'h1);
    tick(1);
    check("hsync_d2", 32'(pif.hsync_out), 32'h0);
    tick(1);
    check("hsync_d3", 32'(pif.hsync_out), 32'h1);

    // Background write of 123: old value after two clocks, new on the third.
    set_layers(4'b0000, 9'o777, 9'o700, 9'o070, 9'o333);
    bg_wr  = 1'b1;
    bg_rgb = 9'o123;
    tick(1);
    bg_wr = 1'b0;
    tick(1);
    check("bg_old", 32'(pif.rgb_out), 32'(9'o007));
    tick(1);
    check("bg_new", 32'(pif.rgb_out), 32'(9'o123));

    // Fade-in request at full level is ignored.
    set_layers(4'b0001, 9'o777, 9'o700, 9'o070, 9'o333);
    tick(2);
    pulse_req(1'b1);
    tick(1);
    check("ignored_busy",  32'(fade_busy),  32'h0);
    check("ignored_level", 32'(fade_level), 32'd16);

    // Fade out of a white pixel.
    pulse_req(1'b0);
    check("fade_busy_rise", 32'(fade_busy), 32'(FADE_EN));
    frames(2);
    check("fade_lvl15", 32'(fade_level), FADE_EN ? 32'd15 : 32'd16);
    tick(2);
    check("fade_rgb15", 32'(pif.rgb_out), FADE_EN ? 32'(9'o666) : 32'(9'o777));
    frames(3);
    pulse_req(1'b1);
    frames(27);
    check("fade_lvl0",  32'(fade_level), FADE_EN ? 32'd0 : 32'd16);
    check("fade_done",  32'(fade_busy),  32'h0);
    tick(2);
    check("fade_black", 32'(pif.rgb_out), FADE_EN ? 32'h0 : 32'(9'o777));

    // Fade back in to level 7, then reset mid-fade with syncs low.
    pulse_req(1'b1);
    frames(14);
    check("fade_in_lvl7", 32'(fade_level), FADE_EN ? 32'd7 : 32'd16);
    pif.hsync_in = 1'b0;
    pif.vsync_in = 1'b0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rgb",   32'(pif.rgb_out),   32'h0);
    check("rst_level", 32'(fade_level),    32'd16);
    check("rst_busy",  32'(fade_busy),     32'h0);
    check("rst_hsync", 32'(pif.hsync_out), 32'h1);
    check("rst_vsync", 32'(pif.vsync_out), 32'h1);
    tick(2);
    rst_n = 1'b1;
    pif.hsync_in = 1'b1;
    pif.vsync_in = 1'b1;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pixel_colouriser.md
# pixel_colouriser

Per-pixel colour output stage for the iTalos VGA path. Merges up to `LAYERS` masked RGB layers and a programmable background by fixed priority, forces black outside the visible area, and optionally applies a frame-synchronous fade-in/fade-out. It sits between the sprite/tile renderers and the DAC pins. Sync signals are delayed alongside the pixel data so they stay aligned with it.

## Interface
- `CW`, default 3: bits per colour channel; pixel word is 3*CW, packed {R,G,B}.
- `LAYERS`, default 4: number of input layers; index 0 has the highest priority.
- `FADE_FRAMES`, default 2: frames per fade step, minimum 1.
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `video_on`  in  1  visible-area flag from the VGA timing generator.
- `hsync_in`, `vsync_in`  in  1 each  raw syncs.
- `frame_start`  in  1  one-cycle pulse per frame.
- `layer_mask`  in  LAYERS  per-layer opaque flag.
- `layer_rgb`  in  LAYERS*3*CW  layer colours; layer k occupies bits [k*3*CW +: 3*CW].
- `bg_wr`  in  1  load strobe for the background register.
- `bg_rgb`  in  3*CW  background colour to load.
- `fade_req`  in  1  fade start pulse.
- `fade_dir`  in  1  1 = fade in (to full), 0 = fade out (to black).
- `rgb_out`  out  3*CW  pixel to the DAC.
- `hsync_out`, `vsync_out`  out  1 each  syncs delayed to match `rgb_out`.
- `fade_busy`  out  1  fade in progress.
- `fade_level`  out  5  current brightness, 0..16.

## Operation
- **Layer selection.** The lowest index k with `layer_mask[k]`=1 wins. If no layer is set, the background register is used.
- **Blanking.** When `video_on`=0 the selected pixel is forced to 0 before the fade stage.
- **Background register.** `bg_wr` loads `bg_rgb` on the clock edge. The new value applies to the pixels sampled on the following cycle. Reset value is 0.
- **Fade scaling.** Each channel is computed as `out = (c * fade_level) >> 4`, using an intermediate of CW+5 bits.
  - Level 16 passes the colour through exactly.
  - Level 0 gives black.
  - The result always fits in CW bits.
- **Fade FSM states:**
  - IDLE: `fade_busy`=0.
  - RUN: `fade_busy`=1.
- **Fade start.** In IDLE, `fade_req` latches `fade_dir`, clears the frame counter and enters RUN.
  - If the level is already at the target (16 for in, 0 for out), the FSM stays in IDLE.
  - `fade_req` received while in RUN is ignored.
- **Fade stepping.** In RUN, each `frame_start` increments the frame counter. When the counter reaches `FADE_FRAMES`:
  - the counter clears;
  - `fade_level` steps ±1 toward the target;
  - on reaching the target, the FSM returns to IDLE in the same cycle.
- **Simultaneous `fade_req` and `frame_start` in IDLE:** start the fade. That `frame_start` is not counted.
- **Reset:**
  - `fade_level`=16, FSM in IDLE, background register = 0.
  - All pipeline registers clear: `rgb_out`=0, `hsync_out`=1, `vsync_out`=1 (syncs are active-low).
  - Asserting reset mid-fade aborts the fade to level 16.

## Timing
- Two-stage pipeline; latency is exactly 2 clocks from inputs to `rgb_out`/`hsync_out`/`vsync_out`.
  - Stage 1 registers the priority/blank result and the syncs.
  - Stage 2 registers the scaled pixel and the syncs.
- `fade_level` changes take effect for pixels that are in stage 2 on the following edge. A fade step never tears within a pixel.
- `fade_busy` rises the cycle after `fade_req` is accepted. It falls in the cycle after the final step.
- Throughput is one pixel per clock with no stalls.

## Configuration
- `PIXEL_COLOURISER_FADE_EN` defined: fade FSM, frame counter and multipliers are present, as described above.
- Undefined:
  - stage 2 is a plain register;
  - `fade_level` is tied to 16 and `fade_busy` to 0;
  - `fade_req`, `fade_dir` and `frame_start` are ignored.
- Latency is 2 clocks in both configurations.

## Structure
- Shared package `italos_video_pkg`:
  - fade level width (5) and full-scale constant (16);
  - FSM state encoding (IDLE/RUN);
  - pixel word width macro 3*CW.
- One sub-module, `fade_scaler`: combinational per-pixel scaling of the three channels by `fade_level`, instantiated inside the FADE_EN branch only.

## Test plan
1. **Priority.** CW=3, masks=4'b0110, layer1=9'o700, layer2=9'o070, video_on=1 → `rgb_out`=9'o700 two clocks later. With masks=0 and bg=9'o007 → 9'o007.
2. **Blanking and syncs.** video_on=0 with any mask set → `rgb_out`=0. A hsync_in low pulse appears on `hsync_out` exactly 2 clocks later.
3. **Background write.** `bg_wr` with 9'o123, then masks=0 → 9'o123 from the third clock after the write.
4. **Fade out.** FADE_FRAMES=2, pixel 9'o777, `fade_req` dir=0:
   - after 2 frame_starts, level=15 and each channel = 6;
   - after 32 frame_starts, level=0, `rgb_out`=0 and `fade_busy` falls.
5. **Ignored request.** `fade_req` dir=1 at level 16 → `fade_busy` stays 0. A second `fade_req` during RUN → level trajectory unchanged.
6. **Reset mid-fade.** Assert `rst_n`=0 at level 7 → immediately `rgb_out`=0, `fade_level`=16, `fade_busy`=0 and syncs high.
